serial_tx_sched: RTL and testbench

Round-robin scheduler that shares one byte-serial transmitter (start bit, 8 data bits LSB first, stop bit) between NUM_REQ requesters. Generates the transmitter's bit-rate clock enable, presents the granted byte on BYTEIN, and strobes LOAD. Tracks frame occupancy itself, because the transmitter has no busy output. Sits between on-chip byte producers (SPI receive path, status logic) and the serial output stage.

---
 rtl/serial_pkg.sv | 39 +++
 rtl/serial_tx_sched_baud.sv | 34 +++
 rtl/serial_tx_sched.sv | 163 ++++++++++++++++
 tb/tb_serial_tx_sched.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types, constants and helpers for the serial transmit scheduler.
package serial_pkg;

  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    SEND    = 2'd2,
    GAP     = 2'd3
  } sched_state_e;

  // Bits needed to hold 0..v-1; never less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // One-hot of the first set request at or above ptr, wrapping within n requesters.
  function automatic logic [7:0] rr_pick(input logic [7:0] req, input int unsigned ptr,
                                         input int unsigned n);
    logic [7:0]  oh;
    logic        found;
    int unsigned idx;
    oh    = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = (ptr + i) % n;
      if ((i < n) && !found && req[idx[2:0]]) begin
        oh[idx[2:0]] = 1'b1;
        found        = 1'b1;
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/serial_tx_sched_baud.sv
// Free-running bit-rate divider producing a one-cycle registered BIT_TICK.
module baud_tick_gen
  import serial_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic CLK,
  input  logic RST_N,
  output logic BIT_TICK
);

  localparam int unsigned CW = clog2(CLKS_PER_BIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == CW'(CLKS_PER_BIT - 1)) ? '0 : cnt_q + CW'(1);
    tick_d = (cnt_d == CW'(CLKS_PER_BIT - 1));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign BIT_TICK = tick_q;

endmodule

// File: rtl/serial_tx_sched.sv
// Round-robin scheduler feeding one byte-serial transmitter.
// Optional SERIAL_SCHED_PRIO0_EN gives requester 0 strict priority.
module serial_tx_sched
  import serial_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned GAP_BITS     = 1
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [NUM_REQ-1:0]        REQ,
  input  logic [8*NUM_REQ-1:0]      REQ_BYTE,
  output logic [NUM_REQ-1:0]        ACK,
  output logic                      BIT_TICK,
  output logic [7:0]                BYTEIN,
  output logic                      LOAD,
  output logic                      BUSY,
  output logic [clog2(NUM_REQ)-1:0] GRANT_ID
);

  localparam int unsigned IW       = clog2(NUM_REQ);
  localparam int unsigned GW       = clog2(GAP_BITS);
  localparam int unsigned GAP_LAST = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

  sched_state_e        state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [3:0]          bitcnt_q, bitcnt_d;
  logic [GW-1:0]       gapcnt_q, gapcnt_d;
  logic [7:0]          byte_q, byte_d;
  logic [IW-1:0]       grant_q, grant_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                load_q, load_d;
  logic                busy_q, busy_d;

  logic                tick;
  logic [7:0]          req_pad;
  logic [NUM_REQ-1:0]  pick_oh;
  logic [IW-1:0]       win_idx;
  logic [IW-1:0]       ptr_next;
  int unsigned         win_int;
  logic                frame_done;

  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .BIT_TICK (tick)
  );

  assign req_pad = 8'(REQ);

  // Winner selection and the pointer value that follows it.
  always_comb begin
`ifdef SERIAL_SCHED_PRIO0_EN
    if (req_pad[0]) pick_oh = NUM_REQ'(8'd1);
    else            pick_oh = NUM_REQ'(rr_pick(req_pad & 8'hFE, 32'(ptr_q), NUM_REQ));
`else
    pick_oh = NUM_REQ'(rr_pick(req_pad, 32'(ptr_q), NUM_REQ));
`endif
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) win_idx = IW'(i);
    end
    win_int  = 32'(win_idx);
    ptr_next = IW'((win_int + 32'd1) % NUM_REQ);
`ifdef SERIAL_SCHED_PRIO0_EN
    if (req_pad[0]) ptr_next = ptr_q;
`endif
  end

  // Frame sequencing; a frame's completion edge doubles as an IDLE grant edge.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    bitcnt_d   = bitcnt_q;
    gapcnt_d   = gapcnt_q;
    byte_d     = byte_q;
    grant_d    = grant_q;
    ack_d      = '0;
    load_d     = load_q;
    busy_d     = busy_q;
    frame_done = 1'b0;

    case (state_q)
      IDLE: ;
      LOADING: begin
        if (tick) begin
          load_d   = 1'b0;
          bitcnt_d = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (tick) begin
          if (bitcnt_q == 4'(FRAME_BITS - 1)) begin
            if (GAP_BITS > 0) begin
              gapcnt_d = '0;
              state_d  = GAP;
            end else begin
              frame_done = 1'b1;
            end
          end else begin
            bitcnt_d = bitcnt_q + 4'd1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gapcnt_q == GW'(GAP_LAST)) frame_done = 1'b1;
          else                           gapcnt_d   = gapcnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (frame_done) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end

    if (((state_q == IDLE) || frame_done) && (|REQ)) begin
      byte_d  = REQ_BYTE[8*win_int +: 8];
      grant_d = win_idx;
      ack_d   = pick_oh;
      load_d  = 1'b1;
      busy_d  = 1'b1;
      ptr_d   = ptr_next;
      state_d = LOADING;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      byte_q   <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      load_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
      byte_q   <= byte_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      load_q   <= load_d;
      busy_q   <= busy_d;
    end
  end

  assign ACK      = ack_q;
  assign BIT_TICK = tick;
  assign BYTEIN   = byte_q;
  assign LOAD     = load_q;
  assign BUSY     = busy_q;
  assign GRANT_ID = grant_q;

endmodule

// File: tb/tb_serial_tx_sched.sv
// Directed bench for serial_tx_sched with NUM_REQ=4, CLKS_PER_BIT=4, GAP_BITS=1.
module tb_serial_tx_sched;

  logic        CLK;
  logic        RST_N;
  logic [3:0]  REQ;
  logic [31:0] REQ_BYTE;
  logic [3:0]  ACK;
  logic        BIT_TICK;
  logic [7:0]  BYTEIN;
  logic        LOAD;
  logic        BUSY;
  logic [1:0]  GRANT_ID;

  int n_cmp  = 0;
  int n_fail = 0;

  serial_tx_sched #(.NUM_REQ(4), .CLKS_PER_BIT(4), .GAP_BITS(1)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .REQ      (REQ),
    .REQ_BYTE (REQ_BYTE),
    .ACK      (ACK),
    .BIT_TICK (BIT_TICK),
    .BYTEIN   (BYTEIN),
    .LOAD     (LOAD),
    .BUSY     (BUSY),
    .GRANT_ID (GRANT_ID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RST_N = 1'b0;
    REQ   = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    logic exp_tick;
    RST_N    = 1'b0;
    REQ      = 4'hF;
    REQ_BYTE = 32'h44332211;
    repeat (3) @(posedge CLK);
    #1;
    n_cmp++; if (ACK !== 4'h0)      begin n_fail++; $display("FAIL rst_ack: got %h want 0", ACK); end
    n_cmp++; if (BIT_TICK !== 1'b0) begin n_fail++; $display("FAIL rst_tick: got %b want 0", BIT_TICK); end
    n_cmp++; if (BYTEIN !== 8'h00)  begin n_fail++; $display("FAIL rst_byte: got %h want 00", BYTEIN); end
    n_cmp++; if (LOAD !== 1'b0)     begin n_fail++; $display("FAIL rst_load: got %b want 0", LOAD); end
    n_cmp++; if (BUSY !== 1'b0)     begin n_fail++; $display("FAIL rst_busy: got %b want 0", BUSY); end
    n_cmp++; if (GRANT_ID !== 2'd0) begin n_fail++; $display("FAIL rst_gid: got %0d want 0", GRANT_ID); end
    REQ   = '0;
    RST_N = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      step();
      exp_tick = ((n % 4) == 3);
      n_cmp++;
      if (BIT_TICK !== exp_tick) begin
        n_fail++; $display("FAIL tick_cycle%0d: got %b want %b", n + 1, BIT_TICK, exp_tick);
      end
    end
  endtask

  task automatic test_single();
    int   ticks;
    int   cyc;
    logic prev_tick;
    apply_reset();
    REQ_BYTE = 32'h000000A5;
    REQ      = 4'b0001;
    step();
    n_cmp++; if (ACK !== 4'b0001)   begin n_fail++; $display("FAIL single_ack: got %b want 0001", ACK); end
    n_cmp++; if (BYTEIN !== 8'hA5)  begin n_fail++; $display("FAIL single_byte: got %h want a5", BYTEIN); end
    n_cmp++; if (GRANT_ID !== 2'd0) begin n_fail++; $display("FAIL single_gid: got %0d want 0", GRANT_ID); end
    n_cmp++; if (LOAD !== 1'b1)     begin n_fail++; $display("FAIL single_load: got %b want 1", LOAD); end
    n_cmp++; if (BUSY !== 1'b1)     begin n_fail++; $display("FAIL single_busy: got %b want 1", BUSY); end
    REQ = '0;
    step();
    n_cmp++; if (ACK !== 4'b0000)   begin n_fail++; $display("FAIL single_ack_pulse: got %b want 0000", ACK); end
    prev_tick = 1'b0;
    cyc = 0;
    while (LOAD === 1'b1 && cyc < 50) begin prev_tick = BIT_TICK; step(); cyc++; end
    n_cmp++;
    if (LOAD !== 1'b0 || prev_tick !== 1'b1) begin
      n_fail++; $display("FAIL single_load_hold: load %b last_tick %b want 0/1", LOAD, prev_tick);
    end
    ticks = 0;
    cyc   = 0;
    while (BUSY === 1'b1 && cyc < 200) begin
      if (BIT_TICK) ticks++;
      prev_tick = BIT_TICK;
      step();
      cyc++;
    end
    n_cmp++;
    if (BUSY !== 1'b0 || ticks != 11 || prev_tick !== 1'b1) begin
      n_fail++; $display("FAIL single_busy_fall: busy %b ticks %0d want 0 after 11 ticks", BUSY, ticks);
    end
  endtask

  task automatic test_round_robin();
    int   cyc;
    logic dropped;
    apply_reset();
    REQ_BYTE = 32'h13121110;
    REQ      = 4'hF;
    dropped  = 1'b0;
    for (int g = 0; g < 6; g++) begin
      cyc = 0;
      step();
      while (ACK === 4'h0 && cyc < 100) begin
        if (BUSY !== 1'b1) dropped = 1'b1;
        step();
        cyc++;
      end
      n_cmp++;
      if (GRANT_ID !== 2'(g % 4) || ACK !== (4'b0001 << (g % 4)) || BYTEIN !== 8'(8'h10 + g % 4)) begin
        n_fail++;
        $display("FAIL rr_grant%0d: gid %0d ack %b byte %h want %0d", g, GRANT_ID, ACK, BYTEIN, g % 4);
      end
    end
    n_cmp++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL rr_back_to_back: busy dropped %b want 0", dropped); end
    REQ = '0;
    cyc = 0;
    while (BUSY === 1'b1 && cyc < 200) begin step(); cyc++; end
  endtask

  task automatic test_busy_request();
    int ticks;
    int cyc;
    apply_reset();
    REQ_BYTE = 32'h003C7700;
    REQ      = 4'b0010;
    step();
    n_cmp++; if (ACK !== 4'b0010) begin n_fail++; $display("FAIL busy_first_ack: got %b want 0010", ACK); end
    REQ = '0;
    cyc = 0;
    while (LOAD === 1'b1 && cyc < 50) begin step(); cyc++; end
    ticks = 0;
    cyc   = 0;
    while (ACK === 4'h0 && cyc < 200) begin
      if (cyc == 8) REQ = 4'b0100;
      if (BIT_TICK) ticks++;
      step();
      cyc++;
    end
    n_cmp++; if (ticks != 11)       begin n_fail++; $display("FAIL busy_ack_early: ack after %0d ticks want 11", ticks); end
    n_cmp++; if (ACK !== 4'b0100)   begin n_fail++; $display("FAIL busy_ack: got %b want 0100", ACK); end
    n_cmp++; if (GRANT_ID !== 2'd2) begin n_fail++; $display("FAIL busy_gid: got %0d want 2", GRANT_ID); end
    n_cmp++; if (BYTEIN !== 8'h3C)  begin n_fail++; $display("FAIL busy_byte: got %h want 3c", BYTEIN); end
    REQ = '0;
    step();
    n_cmp++; if (ACK !== 4'b0000)   begin n_fail++; $display("FAIL busy_ack_pulse: got %b want 0000", ACK); end
  endtask

  task automatic test_reset_mid();
    int ticks;
    int cyc;
    apply_reset();
    REQ_BYTE = 32'hC3005A00;
    REQ      = 4'b0010;
    step();
    REQ = '0;
    cyc = 0;
    while (LOAD === 1'b1 && cyc < 50) begin step(); cyc++; end
    ticks = 0;
    cyc   = 0;
    while (ticks < 5 && cyc < 100) begin if (BIT_TICK) ticks++; step(); cyc++; end
    #2;
    RST_N = 1'b0;
    #1;
    n_cmp++; if (LOAD !== 1'b0)     begin n_fail++; $display("FAIL mid_load: got %b want 0", LOAD); end
    n_cmp++; if (BUSY !== 1'b0)     begin n_fail++; $display("FAIL mid_busy: got %b want 0", BUSY); end
    n_cmp++; if (GRANT_ID !== 2'd0) begin n_fail++; $display("FAIL mid_gid: got %0d want 0", GRANT_ID); end
    n_cmp++; if (BYTEIN !== 8'h00)  begin n_fail++; $display("FAIL mid_byte: got %h want 00", BYTEIN); end
    step();
    RST_N = 1'b1;
    REQ   = 4'b1000;
    step();
    n_cmp++; if (ACK !== 4'b1000)   begin n_fail++; $display("FAIL mid_regrant_ack: got %b want 1000", ACK); end
    n_cmp++; if (GRANT_ID !== 2'd3) begin n_fail++; $display("FAIL mid_regrant_gid: got %0d want 3", GRANT_ID); end
    n_cmp++; if (BYTEIN !== 8'hC3)  begin n_fail++; $display("FAIL mid_regrant_byte: got %h want c3", BYTEIN); end
    REQ = '0;
  endtask

  task automatic test_prio();
    int         cyc;
    logic [1:0] exp_gid [6];
`ifdef SERIAL_SCHED_PRIO0_EN
    exp_gid = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
    exp_gid = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
`endif
    apply_reset();
    REQ_BYTE = 32'hD3D2D1D0;
    REQ      = 4'b1011;
    for (int g = 0; g < 6; g++) begin
      cyc = 0;
      step();
      while (ACK === 4'h0 && cyc < 100) begin step(); cyc++; end
      n_cmp++;
      if (GRANT_ID !== exp_gid[g] || ACK !== (4'b0001 << exp_gid[g])) begin
        n_fail++; $display("FAIL prio_grant%0d: gid %0d ack %b want %0d", g, GRANT_ID, ACK, exp_gid[g]);
      end
    end
    REQ = '0;
  endtask

  initial begin
    RST_N    = 1'b0;
    REQ      = '0;
    REQ_BYTE = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_busy_request();
    test_reset_mid();
    test_prio();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
